recip_nr_ctrl: RTL and testbench
================================

RECIP_NR_CTRL -- requirements
Module: recip_nr_ctrl

Interface
REQ-001 SHALL have parameter NEXP, default 5, exponent width (carried for family consistency, unused in datapath).
REQ-002 SHALL have parameter NSIG, default 11, significand width including hidden bit; fixed-point width W = NSIG+2.
REQ-003 SHALL have parameter ITERS, default 2, number of Newton-Raphson iterations (0..7).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a reciprocal of 1.frac.
REQ-007 frac  input  NSIG-1  divisor fraction bits (hidden 1 implied); sampled with start.
REQ-008 abort  input  1  cancel operation in progress.
REQ-009 busy  output  1  high from accepted start until DONE or abort.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 result  output  W  reciprocal, unsigned Q1.(W-1); held until next accepted start.
REQ-012 lut_addr  output  NSIG-1  address to seed LUT (combinational read, data same cycle).
REQ-013 lut_data  input  W  seed 1/d from LUT, Q1.(W-1).
REQ-014 mul_req  output  1  shared multiplier request.
REQ-015 mul_a, mul_b  output  W each  multiplier operands, unsigned Q1.(W-1).
REQ-016 mul_ack  input  1  multiplier grant+product valid this cycle.
REQ-017 mul_p  input  2W  product, Q2.(2W-2), valid only when mul_ack=1.

Function
REQ-018 States: IDLE, SEED, MUL_DX, MUL_XE, DONE.
REQ-019 IDLE: start=1 and abort=0 registers frac, sets busy, -> SEED; start while not IDLE SHALL be ignored.
REQ-020 SEED (one cycle): lut_addr = registered frac; x <= lut_data; iteration counter <= 0; -> MUL_DX if ITERS>0 else DONE.
REQ-021 Operand d = {1'b1, frac, 2'b00} (Q1.(W-1)).
REQ-022 MUL_DX: mul_req=1, mul_a=d, mul_b=x; on mul_ack: t = mul_p[2W-1:W-1] (Q2.(W-1)); e <= 2.0 - t, forced to 0 if t >= 2.0; -> MUL_XE.
REQ-023 MUL_XE: mul_req=1, mul_a=x, mul_b=e; on mul_ack: x <= mul_p[2W-2:W-1], saturated to all-ones if mul_p[2W-1]=1; counter+1; -> MUL_DX if counter+1<ITERS else DONE.
REQ-024 mul_req SHALL stay high and mul_a/mul_b stable until mul_ack; mul_ack outside MUL_DX/MUL_XE SHALL be ignored; mul_req=0 in all other states.
REQ-025 DONE (one cycle): result <= x, done=1, busy=0, -> IDLE.
REQ-026 Latency with mul_ack tied high: done asserted in cycle 2+2*ITERS after the start cycle (cycle 6 for ITERS=2); each multiplier wait cycle adds one.
REQ-027 abort in any non-IDLE state SHALL -> IDLE on next edge, drop mul_req and busy, no done, result unchanged; abort in DONE state suppresses nothing (done already issued that cycle).
REQ-028 Simultaneous start and abort in IDLE: abort wins, start not accepted.
REQ-029 A start in the cycle done is asserted SHALL be ignored (state is DONE, not IDLE).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, mul_req=0, result=0, lut_addr=0, x=0, e=0, counter=0, including mid-operation; no done follows deassertion.

Verification
REQ-031 frac=0, ITERS=2, mul_ack=1, LUT seed 13'h1000 -> done in cycle 6, result=13'h1000.
REQ-032 frac=10'h3FF, random LUT contents -> result equals bit-exact model of REQ-021..023.
REQ-033 mul_ack delayed 3 cycles per request, ITERS=2 -> done in cycle 18, operands stable throughout each wait.
REQ-034 abort asserted during second MUL_XE -> busy=0 next cycle, no done, result keeps previous value.
REQ-035 rst_n pulsed low during MUL_DX -> all outputs zero asynchronously, IDLE after release, next start completes normally.
REQ-036 ITERS=0, frac=10'h155 -> done in cycle 2, result=lut_data[0x155], mul_req never asserted.

Source files
------------

// File: rtl/recip_nr_ctrl.sv
// rtl/recip_nr_ctrl.sv - Newton-Raphson reciprocal sequencer driving a seed LUT and a shared multiplier
module recip_nr_ctrl #(
    parameter int NEXP  = 5,
    parameter int NSIG  = 11,
    parameter int ITERS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NSIG-2:0]   frac,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [NSIG+1:0]   result,
    output logic [NSIG-2:0]   lut_addr,
    input  logic [NSIG+1:0]   lut_data,
    output logic              mul_req,
    output logic [NSIG+1:0]   mul_a,
    output logic [NSIG+1:0]   mul_b,
    input  logic              mul_ack,
    input  logic [2*NSIG+3:0] mul_p
);

    localparam int W = NSIG + 2;
    // Exponent width only keeps the parameter set aligned with the rest of the FP family.
    localparam int unused_nexp = NEXP;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEED   = 3'd1;
    localparam logic [2:0] S_MUL_DX = 3'd2;
    localparam logic [2:0] S_MUL_XE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      state;
    logic [NSIG-2:0] frac_r;
    logic [W-1:0]    x;
    logic [W-1:0]    e;
    logic [2:0]      cnt;

    logic [W-1:0]    d;
    logic [W:0]      t;
    logic [W:0]      two_minus_t;
    logic [W-1:0]    e_nx;
    logic [W-1:0]    x_nx;
    logic [3:0]      cnt_inc;
    logic            last_iter;
    logic            unused_bits;

    assign d = {1'b1, frac_r, 2'b00};

    // t is Q2.(W-1): bit W carries the 2.0 weight, so t >= 2.0 is just t[W].
    assign t           = mul_p[2*W-1:W-1];
    assign two_minus_t = {1'b1, {W{1'b0}}} - t;
    assign e_nx        = t[W] ? '0 : two_minus_t[W-1:0];
    assign x_nx        = mul_p[2*W-1] ? '1 : mul_p[2*W-2:W-1];
    assign unused_bits = ^mul_p[W-2:0];

    assign cnt_inc   = {1'b0, cnt} + 4'd1;
    assign last_iter = (cnt_inc >= 4'(ITERS));

    assign lut_addr = frac_r;
    assign busy     = (state == S_SEED) || (state == S_MUL_DX) || (state == S_MUL_XE);
    assign done     = (state == S_DONE);
    assign mul_req  = (state == S_MUL_DX) || (state == S_MUL_XE);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == S_MUL_DX) begin
            mul_a = d;
            mul_b = x;
        end else if (state == S_MUL_XE) begin
            mul_a = x;
            mul_b = e;
        end
    end

    // result is loaded on entry to DONE so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            frac_r <= '0;
            x      <= '0;
            e      <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        frac_r <= frac;
                        state  <= S_SEED;
                    end
                end
                S_SEED: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        x   <= lut_data;
                        cnt <= '0;
                        if (ITERS > 0) begin
                            state <= S_MUL_DX;
                        end else begin
                            result <= lut_data;
                            state  <= S_DONE;
                        end
                    end
                end
                S_MUL_DX: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (mul_ack) begin
                        e     <= e_nx;
                        state <= S_MUL_XE;
                    end
                end
                S_MUL_XE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (mul_ack) begin
                        x   <= x_nx;
                        cnt <= cnt_inc[2:0];
                        if (last_iter) begin
                            result <= x_nx;
                            state  <= S_DONE;
                        end else begin
                            state <= S_MUL_DX;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recip_nr_ctrl.sv
// tb/tb_recip_nr_ctrl.sv - scoreboard bench for recip_nr_ctrl against an arithmetic reciprocal model
module tb_recip_nr_ctrl;

    localparam int NSIG = 11;
    localparam int W    = NSIG + 2;
    localparam int FW   = NSIG - 1;
    localparam int PW   = 2 * W;

    typedef struct {
        logic [W-1:0] res;
        int           t0;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [W-1:0] lut [0:(1<<FW)-1];

    logic          start, abort;
    logic [FW-1:0] frac;
    logic          busy, done;
    logic [W-1:0]  result;
    logic [FW-1:0] lut_addr;
    logic [W-1:0]  lut_data;
    logic          mul_req;
    logic [W-1:0]  mul_a, mul_b;
    logic          mul_ack;
    logic [PW-1:0] mul_p;

    logic          start0;
    logic          abort0;
    logic [FW-1:0] frac0;
    logic          busy0, done0;
    logic [W-1:0]  result0;
    logic [FW-1:0] lut_addr0;
    logic [W-1:0]  lut_data0;
    logic          mul_req0;
    logic [W-1:0]  mul_a0, mul_b0;
    logic          mul_ack0;
    logic [PW-1:0] mul_p0;

    logic [PW-1:0] junk = '0;
    int  wcnt = 0;
    int  cur_delay = 0;
    int  fixed_delay = 0;
    bit  rand_delay = 1'b0;

    exp_t q[$];
    exp_t q0[$];
    int errors = 0;
    int checks = 0;
    logic [W-1:0] cap_a, cap_b;
    logic [W-1:0] last_res;
    bit saw_req0 = 1'b0;

    recip_nr_ctrl #(.NEXP(5), .NSIG(NSIG), .ITERS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frac(frac), .abort(abort),
        .busy(busy), .done(done), .result(result), .lut_addr(lut_addr), .lut_data(lut_data),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p)
    );

    recip_nr_ctrl #(.NEXP(5), .NSIG(NSIG), .ITERS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .frac(frac0), .abort(abort0),
        .busy(busy0), .done(done0), .result(result0), .lut_addr(lut_addr0), .lut_data(lut_data0),
        .mul_req(mul_req0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_ack(mul_ack0), .mul_p(mul_p0)
    );

    assign lut_data  = lut[lut_addr];
    assign lut_data0 = lut[lut_addr0];
    assign abort0    = 1'b0;
    assign mul_ack0  = 1'b1;
    assign mul_p0    = junk;

    // Multiplier model: grants after cur_delay wait cycles, garbage product otherwise.
    always @(posedge clk) begin
        junk <= PW'({$urandom, $urandom});
        if (mul_req && !mul_ack) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt      <= 0;
            cur_delay <= rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end
    end
    assign mul_ack = mul_req && (wcnt >= cur_delay);
    assign mul_p   = mul_ack ? PW'(mul_a) * PW'(mul_b) : junk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_recip(input int fr, input int iters);
        longint one, d, x, t, e, p;
        one = longint'(1) << (W - 1);
        d   = one + longint'(fr) * 4;
        x   = longint'(lut[fr]);
        for (int i = 0; i < iters; i++) begin
            t = (d * x) >> (W - 1);
            e = (t >= 2 * one) ? 0 : ((2 * one - t) % (2 * one));
            p = x * e;
            x = (p >= (longint'(1) << (PW - 1))) ? (2 * one - 1) : ((p >> (W - 1)) % (2 * one));
        end
        return W'(x);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    exp_t ex;
                    ex = q.pop_front();
                    chk("result", 64'(result), 64'(ex.res));
                    if (ex.lat >= 0) chk("latency", 64'(cyc - ex.t0), 64'(ex.lat));
                end
            end
            if (mul_req) begin
                if (wcnt == 0) begin
                    cap_a = mul_a;
                    cap_b = mul_b;
                end else begin
                    chk("mul_a_stable", 64'(mul_a), 64'(cap_a));
                    chk("mul_b_stable", 64'(mul_b), 64'(cap_b));
                end
            end
            if (mul_req0) saw_req0 = 1'b1;
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_done0", 64'(done0), 64'(0));
                end else begin
                    exp_t ex0;
                    ex0 = q0.pop_front();
                    chk("result_iters0", 64'(result0), 64'(ex0.res));
                    chk("latency_iters0", 64'(cyc - ex0.t0), 64'(ex0.lat));
                end
            end
        end
    end

    task automatic issue(input int fr, input int lat);
        exp_t ex;
        @(negedge clk);
        start = 1'b1;
        frac  = FW'(fr);
        ex.res = ref_recip(fr, 2);
        ex.t0  = cyc;
        ex.lat = lat;
        q.push_back(ex);
        last_res = ex.res;
        @(negedge clk);
        start = 1'b0;
        frac  = FW'($urandom);
    endtask

    task automatic issue0(input int fr);
        exp_t ex;
        @(negedge clk);
        start0 = 1'b1;
        frac0  = FW'(fr);
        ex.res = lut[fr];
        ex.t0  = cyc;
        ex.lat = 2;
        q0.push_back(ex);
        @(negedge clk);
        start0 = 1'b0;
        frac0  = FW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || q0.size() != 0 || busy || busy0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_idle_timeout: waited %0d cycles, required < 400", n);
            q.delete();
            q0.delete();
        end
    endtask

    initial begin
        int fr;
        int n;
        start = 1'b0; abort = 1'b0; frac = '0;
        start0 = 1'b0; frac0 = '0;
        last_res = '0;
        for (int i = 0; i < (1 << FW); i++) lut[i] = W'($urandom_range(0, (1 << W) - 1));

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_mul_req", 64'(mul_req), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_lut_addr", 64'(lut_addr), 64'(0));
        chk("rst_mul_a", 64'(mul_a), 64'(0));
        chk("rst_busy0", 64'(busy0), 64'(0));
        rst_n = 1'b1;

        lut[0] = 13'h1000;
        issue(0, 6);
        wait_idle();
        chk("unity_result_held", 64'(result), 64'(13'h1000));

        issue(10'h3FF, 6);
        wait_idle();

        for (int k = 0; k < 8; k++) begin
            issue(int'($urandom_range(0, (1 << FW) - 1)), 6);
            wait_idle();
        end

        fixed_delay = 3;
        issue(int'($urandom_range(0, (1 << FW) - 1)), 18);
        wait_idle();
        fixed_delay = 0;

        rand_delay = 1'b1;
        for (int k = 0; k < 6; k++) begin
            issue(int'($urandom_range(0, (1 << FW) - 1)), -1);
            wait_idle();
        end
        rand_delay = 1'b0;
        repeat (2) @(negedge clk);

        // Start while busy must not disturb the running operation.
        issue(int'($urandom_range(0, (1 << FW) - 1)), 6);
        @(negedge clk);
        start = 1'b1; frac = FW'($urandom);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start coinciding with done is dropped.
        issue(int'($urandom_range(0, (1 << FW) - 1)), 6);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done), 64'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'(0));
        repeat (8) @(negedge clk);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'(0));
        repeat (8) @(negedge clk);

        // Abort in the second MUL_XE cycle.
        fr = int'($urandom_range(0, (1 << FW) - 1));
        @(negedge clk);
        start = 1'b1; frac = FW'(fr);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'(1));
        chk("pre_abort_xe_mul_a", 64'(mul_a), 64'(ref_recip(fr, 1)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_mul_req", 64'(mul_req), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_result_kept", 64'(result), 64'(last_res));
        repeat (10) @(negedge clk);

        // Asynchronous reset during MUL_DX.
        @(negedge clk);
        start = 1'b1; frac = FW'($urandom_range(1, (1 << FW) - 1));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_mul_req", 64'(mul_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_mul_req", 64'(mul_req), 64'(0));
        chk("async_rst_result", 64'(result), 64'(0));
        chk("async_rst_lut_addr", 64'(lut_addr), 64'(0));
        chk("async_rst_mul_b", 64'(mul_b), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(int'($urandom_range(0, (1 << FW) - 1)), 6);
        wait_idle();

        issue0(10'h155);
        wait_idle();
        issue0(int'($urandom_range(0, (1 << FW) - 1)));
        wait_idle();
        chk("iters0_no_mul_req", 64'(saw_req0), 64'(0));

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion before 500000");
        $fatal(1);
    end

endmodule
